// File: rtl/brl_pkg.sv
// Shared types and helpers for the barrel un-rotate datapath.
package brl_pkg;

  localparam int DATA_SIZE = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ROT  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Smallest r with 2**r >= value; exact for the power-of-two widths used here.
  function automatic integer log2(input logic [31:0] value);
    integer r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < {32'd0, value}) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/barrel_rotl.sv
// Combinational left rotator: one conditional power-of-two stage per bit of amt_i.
module barrel_rotl #(
  parameter int WIDTH = 8,
  parameter int SHW   = 3
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic [SHW-1:0]   amt_i,
  output logic [WIDTH-1:0] data_o
);

  logic [WIDTH-1:0] stage;

  always_comb begin
    // NOTE: blocking assignments here are intentional; each stage must see the previous one within the same evaluation.
    stage = data_i;
    for (int k = 0; k < SHW; k++) begin
      if (amt_i[k]) stage = (stage << (2 ** k)) | (stage >> (WIDTH - 2 ** k));
    end
    data_o = stage;
  end

endmodule

// File: rtl/barrel_unrotate.sv
// Iterative left rotator restoring a word that was rotated right by sel.
// Define BRL_UNROT_FAST_EN for a single-cycle combinational rotate on accept.
module barrel_unrotate
  import brl_pkg::*;
#(
  parameter  int data_size = DATA_SIZE,
  localparam int SEL_W     = log2(data_size)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [SEL_W-1:0]     sel,
  input  logic [data_size-1:0] data_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [data_size-1:0] data_out,
  output logic                 busy
);

  state_t               state_q, state_d;
  logic [data_size-1:0] shreg_q, shreg_d;
  logic [SEL_W-1:0]     cnt_q, cnt_d;

`ifdef BRL_UNROT_FAST_EN
  logic [data_size-1:0] rot_in;

  barrel_rotl #(
    .WIDTH (data_size),
    .SHW   (SEL_W)
  ) u_rotl (
    .data_i (data_in),
    .amt_i  (sel),
    .data_o (rot_in)
  );
`endif

  always_comb begin
    // NOTE: every next-state value gets a default first so no path leaves one unassigned and infers a latch.
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          cnt_d = sel;
`ifdef BRL_UNROT_FAST_EN
          shreg_d = rot_in;
          state_d = DONE;
`else
          shreg_d = data_in;
          state_d = (sel == '0) ? DONE : ROT;
`endif
        end
      end
      ROT: begin
        shreg_d = {shreg_q[data_size-2:0], shreg_q[data_size-1]};
        cnt_d   = cnt_q - SEL_W'(1);
        // Counter of 1 means this edge performs the final rotation.
        if (cnt_q == SEL_W'(1)) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: state registers use non-blocking assignments so every flop updates from pre-edge values.
    if (reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign data_out  = shreg_q;

endmodule
